// File: rtl/cgra_clock_gate_ctrl.sv
// cgra_clock_gate_ctrl
// Enable controller for the CGRA clock-gate cell. A software gate request
// drains the CGRA to a guaranteed-idle point, drops the enable, and on a
// wake cause restores the clock and holds ready_o low for a settle period.
//
// Optional build macro: CGRA_CLK_GATE_STATS_EN
//   Adds gated_cycles_o (32-bit, wraps), gate_events_o (16-bit, saturates)
//   and stats_clr_i (synchronous clear, wins over a same-cycle increment).
//
// All outputs are registered; they are computed from the next state so
// they take their state's values on the cycle that state is entered.
module cgra_clock_gate_ctrl #(
  parameter int unsigned IDLE_CYCLES = 4,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        test_en_i,
  input  logic        gate_req_i,
  input  logic        cgra_busy_i,
  input  logic        start_pending_i,
`ifdef CGRA_CLK_GATE_STATS_EN
  input  logic        stats_clr_i,
  output logic [31:0] gated_cycles_o,
  output logic [15:0] gate_events_o,
`endif
  output logic        en_o,
  output logic        gated_o,
  output logic        ready_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } state_e;

  // A zero idle or wake length would leave no cycle in which to count, so
  // both are floored at one.
  localparam int unsigned IDLE_EFF = (IDLE_CYCLES < 1) ? 1 : IDLE_CYCLES;
  localparam int unsigned WAKE_EFF = (WAKE_CYCLES < 1) ? 1 : WAKE_CYCLES;

  // Terminal counter values: the transition fires while the counter holds
  // the terminal value, which gives exactly N cycles of dwell.
  localparam logic [CNT_W-1:0] IDLE_TERM = CNT_W'(IDLE_EFF - 1);
  localparam logic [CNT_W-1:0] WAKE_TERM = CNT_W'(WAKE_EFF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             gated_q, gated_d;
  logic             ready_q, ready_d;

  // Any of these means the clock must be (or stay) running.
  logic             wake_cause;
  assign wake_cause = !gate_req_i || start_pending_i || test_en_i;

  // State, counter and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      en_q    <= 1'b1;
      gated_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      gated_q <= gated_d;
      ready_q <= ready_d;
    end
  end

  // Next-state and counter logic. The counter is cleared on every state
  // entry and only increments below its terminal value, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (gate_req_i && !start_pending_i && !test_en_i) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        // Abort is checked first so it beats both busy and gating.
        if (wake_cause) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (cgra_busy_i) begin
          cnt_d = '0;
        end else if (cnt_q >= IDLE_TERM) begin
          state_d = ST_GATED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_GATED: begin
        // Busy is a don't-care here: the CGRA has no clock.
        if (wake_cause) begin
          state_d = ST_WAKE;
          cnt_d   = '0;
        end
      end
      ST_WAKE: begin
        // Requests are ignored until the clock has settled and RUN is
        // reached, guaranteeing at least one RUN cycle between gatings.
        if (cnt_q >= WAKE_TERM) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state, registered above.
  always_comb begin
    en_d    = 1'b1;
    gated_d = 1'b0;
    ready_d = 1'b0;
    unique case (state_d)
      ST_RUN: begin
        ready_d = 1'b1;
      end
      ST_DRAIN: begin
        ready_d = 1'b0;
      end
      ST_GATED: begin
        en_d    = 1'b0;
        gated_d = 1'b1;
      end
      ST_WAKE: begin
        ready_d = 1'b0;
      end
      default: begin
        en_d    = 1'b1;
        gated_d = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  assign en_o    = en_q;
  assign gated_o = gated_q;
  assign ready_o = ready_q;
  assign state_o = state_q;

`ifdef CGRA_CLK_GATE_STATS_EN
  logic [31:0] gated_cycles_q;
  logic [15:0] gate_events_q;
  logic        gate_entry;

  assign gate_entry = (state_q == ST_DRAIN) && (state_d == ST_GATED);

  // Statistics: clear wins over any increment in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || stats_clr_i) begin
      gated_cycles_q <= '0;
      gate_events_q  <= '0;
    end else begin
      if (state_q == ST_GATED) begin
        gated_cycles_q <= gated_cycles_q + 32'd1;
      end
      if (gate_entry && (gate_events_q != 16'hFFFF)) begin
        gate_events_q <= gate_events_q + 16'd1;
      end
    end
  end

  assign gated_cycles_o = gated_cycles_q;
  assign gate_events_o  = gate_events_q;
`endif

endmodule

// File: tb/tb_cgra_clock_gate_ctrl.sv
// Directed bench for cgra_clock_gate_ctrl (IDLE_CYCLES=4, WAKE_CYCLES=2),
// with a second instance at WAKE_CYCLES=0 sharing the same inputs.
module tb_cgra_clock_gate_ctrl;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic test_en_i = 1'b0;
  logic gate_req_i = 1'b0;
  logic cgra_busy_i = 1'b0;
  logic start_pending_i = 1'b0;

  logic       en_o, gated_o, ready_o;
  logic [1:0] state_o;
  logic       en0_o, gated0_o, ready0_o;
  logic [1:0] state0_o;

`ifdef CGRA_CLK_GATE_STATS_EN
  logic        stats_clr_i = 1'b0;
  logic [31:0] gated_cycles_o, gated_cycles0_o;
  logic [15:0] gate_events_o, gate_events0_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  cgra_clock_gate_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(2), .CNT_W(8)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .test_en_i(test_en_i),
    .gate_req_i(gate_req_i), .cgra_busy_i(cgra_busy_i),
    .start_pending_i(start_pending_i),
`ifdef CGRA_CLK_GATE_STATS_EN
    .stats_clr_i(stats_clr_i), .gated_cycles_o(gated_cycles_o),
    .gate_events_o(gate_events_o),
`endif
    .en_o(en_o), .gated_o(gated_o), .ready_o(ready_o), .state_o(state_o)
  );

  cgra_clock_gate_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(0), .CNT_W(8)) u_dut_w0 (
    .clk_i(clk_i), .rst_i(rst_i), .test_en_i(test_en_i),
    .gate_req_i(gate_req_i), .cgra_busy_i(cgra_busy_i),
    .start_pending_i(start_pending_i),
`ifdef CGRA_CLK_GATE_STATS_EN
    .stats_clr_i(stats_clr_i), .gated_cycles_o(gated_cycles0_o),
    .gate_events_o(gate_events0_o),
`endif
    .en_o(en0_o), .gated_o(gated0_o), .ready_o(ready0_o), .state_o(state0_o)
  );

  typedef struct {
    logic       rst, test, req, busy, start;
    logic       en, gated, ready;
    logic [1:0] st;
  } vec_t;

  localparam int NV = 38;
  vec_t vecs[NV];

  // Expected outputs per state: RUN 1/0/1, DRAIN 1/0/0, GATED 0/1/0, WAKE 1/0/0.
  function automatic vec_t mk(input logic rst, input logic test, input logic req,
                              input logic busy, input logic start, input logic [1:0] st);
    vec_t v;
    v.rst = rst; v.test = test; v.req = req; v.busy = busy; v.start = start;
    v.st = st;
    v.en    = (st != 2'd2);
    v.gated = (st == 2'd2);
    v.ready = (st == 2'd0);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic rst, input logic test, input logic req,
                     input logic busy, input logic start);
    rst_i = rst; test_en_i = test; gate_req_i = req;
    cgra_busy_i = busy; start_pending_i = start;
    @(posedge clk_i);
    #1;
    $display("cyc rst=%0b test=%0b req=%0b busy=%0b start=%0b -> st=%0d en=%0b g=%0b r=%0b | w0 st=%0d",
             rst, test, req, busy, start, state_o, en_o, gated_o, ready_o, state0_o);
  endtask

  task automatic chk_main(input string tag, input logic en, input logic g,
                          input logic r, input logic [1:0] st);
    chk({tag, "_en"}, {31'd0, en_o}, {31'd0, en});
    chk({tag, "_gated"}, {31'd0, gated_o}, {31'd0, g});
    chk({tag, "_ready"}, {31'd0, ready_o}, {31'd0, r});
    chk({tag, "_state"}, {30'd0, state_o}, {30'd0, st});
  endtask

  initial begin
    //                rst test req busy start  state
    vecs[0]  = mk(1, 0, 0, 0, 0, 2'd0); // reset
    vecs[1]  = mk(0, 0, 0, 0, 0, 2'd0);
    vecs[2]  = mk(0, 0, 1, 0, 0, 2'd1); // request edge
    vecs[3]  = mk(0, 0, 1, 0, 0, 2'd1);
    vecs[4]  = mk(0, 0, 1, 0, 0, 2'd1);
    vecs[5]  = mk(0, 0, 1, 0, 0, 2'd1);
    vecs[6]  = mk(0, 0, 1, 0, 0, 2'd2); // gated 5 edges after request
    vecs[7]  = mk(0, 0, 1, 1, 0, 2'd2); // busy ignored while gated
    vecs[8]  = mk(0, 0, 1, 0, 1, 2'd3); // start pending wakes, en=1
    vecs[9]  = mk(0, 0, 1, 0, 1, 2'd3);
    vecs[10] = mk(0, 0, 1, 0, 1, 2'd0); // ready 3 cycles after cause
    vecs[11] = mk(0, 0, 1, 0, 1, 2'd0); // pending blocks re-gate
    vecs[12] = mk(0, 0, 1, 0, 0, 2'd1);
    vecs[13] = mk(0, 0, 1, 0, 0, 2'd1);
    vecs[14] = mk(0, 0, 1, 0, 0, 2'd1);
    vecs[15] = mk(0, 0, 1, 1, 0, 2'd1); // busy in 3rd drain cycle
    vecs[16] = mk(0, 0, 1, 0, 0, 2'd1);
    vecs[17] = mk(0, 0, 1, 0, 0, 2'd1);
    vecs[18] = mk(0, 0, 1, 0, 0, 2'd1);
    vecs[19] = mk(0, 0, 1, 0, 0, 2'd2); // 4 cycles after busy drops
    vecs[20] = mk(0, 0, 0, 0, 0, 2'd3); // request released
    vecs[21] = mk(0, 0, 1, 0, 0, 2'd3); // request ignored in wake
    vecs[22] = mk(0, 0, 1, 0, 0, 2'd0);
    vecs[23] = mk(0, 0, 1, 0, 0, 2'd1); // one RUN cycle then drain
    vecs[24] = mk(0, 1, 1, 0, 0, 2'd0); // test_en aborts drain
    vecs[25] = mk(0, 1, 1, 0, 0, 2'd0);
    vecs[26] = mk(0, 1, 1, 0, 0, 2'd0); // test_en holds RUN
    vecs[27] = mk(0, 0, 1, 0, 0, 2'd1);
    vecs[28] = mk(0, 0, 0, 1, 0, 2'd0); // abort beats busy
    vecs[29] = mk(0, 0, 1, 0, 0, 2'd1);
    vecs[30] = mk(0, 0, 1, 0, 0, 2'd1);
    vecs[31] = mk(0, 0, 1, 0, 0, 2'd1);
    vecs[32] = mk(0, 0, 1, 0, 0, 2'd1);
    vecs[33] = mk(0, 0, 1, 0, 0, 2'd2);
    vecs[34] = mk(0, 1, 1, 0, 0, 2'd3); // test_en wakes from gated
    vecs[35] = mk(0, 1, 1, 0, 0, 2'd3);
    vecs[36] = mk(0, 1, 1, 0, 0, 2'd0);
    vecs[37] = mk(0, 1, 1, 0, 0, 2'd0);

    for (int i = 0; i < NV; i++) begin
      cyc(vecs[i].rst, vecs[i].test, vecs[i].req, vecs[i].busy, vecs[i].start);
      chk_main($sformatf("v%0d", i), vecs[i].en, vecs[i].gated, vecs[i].ready, vecs[i].st);
    end

    // Reset while gated, then release reset.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0);
    chk_main("rg_pre", 1'b0, 1'b1, 1'b0, 2'd2);
    cyc(1, 0, 1, 0, 0);
    chk_main("rg_rst", 1'b1, 1'b0, 1'b1, 2'd0);
`ifdef CGRA_CLK_GATE_STATS_EN
    chk("rg_gcyc", gated_cycles_o, 32'd0);
    chk("rg_gev", {16'd0, gate_events_o}, 32'd0);
`endif
    cyc(0, 0, 0, 0, 0);
    chk_main("rg_post", 1'b1, 1'b0, 1'b1, 2'd0);

    // WAKE_CYCLES=0 instance: exactly one WAKE cycle.
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0);
    chk("w0_gated", {30'd0, state0_o}, 32'd2);
    cyc(0, 0, 0, 0, 0);
    chk("w0_wake", {30'd0, state0_o}, 32'd3);
    chk("w0_wake_en", {31'd0, en0_o}, 32'd1);
    chk("w0_wake_rdy", {31'd0, ready0_o}, 32'd0);
    chk("w2_wake1", {30'd0, state_o}, 32'd3);
    cyc(0, 0, 0, 0, 0);
    chk("w0_run", {30'd0, state0_o}, 32'd0);
    chk("w0_run_rdy", {31'd0, ready0_o}, 32'd1);
    chk("w2_wake2", {30'd0, state_o}, 32'd3);
    cyc(0, 0, 0, 0, 0);
    chk("w2_run", {30'd0, state_o}, 32'd0);

`ifdef CGRA_CLK_GATE_STATS_EN
    // Busy restart: one gating event, then three gated cycles counted.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0); // enter DRAIN
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0); // busy in 3rd drain cycle
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("st_gev_pre", {16'd0, gate_events_o}, 32'd0);
    chk("st_en_pre", {31'd0, en_o}, 32'd1);
    cyc(0, 0, 1, 0, 0);
    chk("st_en_gate", {31'd0, en_o}, 32'd0);
    chk("st_gev_one", {16'd0, gate_events_o}, 32'd1);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0); // wake; three GATED cycles elapsed
    chk("st_gcyc3", gated_cycles_o, 32'd3);
    chk("st_gev_hold", {16'd0, gate_events_o}, 32'd1);

    // Clear coincident with the DRAIN->GATED increment, then while gated.
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0);
    stats_clr_i = 1'b1;
    cyc(0, 0, 1, 0, 0);
    chk("clr_gev", {16'd0, gate_events_o}, 32'd0);
    chk("clr_state", {30'd0, state_o}, 32'd2);
    stats_clr_i = 1'b0;
    cyc(0, 0, 1, 0, 0);
    chk("clr_gcyc1", gated_cycles_o, 32'd1);
    stats_clr_i = 1'b1;
    cyc(0, 0, 1, 0, 0);
    chk("clr_gcyc0", gated_cycles_o, 32'd0);
    stats_clr_i = 1'b0;
    cyc(0, 0, 1, 0, 0);
    chk("clr_gcyc_re", gated_cycles_o, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cgra_clock_gate_ctrl.md
Name: cgra_clock_gate_ctrl

Overview:
- Enable controller driving the `en_i` input of the CGRA clock-gate cell; it is the producer side of that interface.
- Takes a software gate request and the CGRA busy status.
- Drains to a guaranteed-idle point, drops the enable, and restores the clock on wake.
- Signals `ready_o` only after a programmable settle period.
- Sits between the CGRA control/status registers and the CGRA clock-gate instance.

Parameters:
- IDLE_CYCLES, 4: consecutive idle cycles required in DRAIN before gating; legal range 1..255.
- WAKE_CYCLES, 2: settle cycles after the enable is re-asserted before `ready_o`; legal range 0..255, where 0 is treated as 1.
- CNT_W, 8: width of the internal idle/wake counter; must hold max(IDLE_CYCLES, WAKE_CYCLES).

Ports:
- clk_i  in  1  free-running clock (ungated side).
- rst_i  in  1  synchronous reset, active-high.
- test_en_i  in  1  scan/test mode; blocks gating.
- gate_req_i  in  1  level request to gate the CGRA clock.
- cgra_busy_i  in  1  CGRA executing or has outstanding memory transactions.
- start_pending_i  in  1  kernel start queued; forces the clock on.
- en_o  out  1  enable to the clock-gate cell; registered.
- gated_o  out  1  clock currently gated.
- ready_o  out  1  clock running and settled; CGRA may be started.
- state_o  out  2  FSM state encoding: RUN=0, DRAIN=1, GATED=2, WAKE=3.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state=RUN, counter=0.
  - Outputs: en_o=1, gated_o=0, ready_o=1.
  - Reset mid-DRAIN, mid-GATED or mid-WAKE returns to RUN; en_o=1 on the next cycle.
- All outputs are registered and take their state's values on the cycle the state is entered.
- RUN:
  - Outputs: en_o=1, ready_o=1, gated_o=0.
  - Go to DRAIN when gate_req_i=1 && start_pending_i=0 && test_en_i=0; counter cleared.
- DRAIN:
  - Outputs: en_o=1, ready_o=0, gated_o=0.
  - Abort to RUN if gate_req_i=0, start_pending_i=1 or test_en_i=1. The abort takes priority over gating.
  - If cgra_busy_i=1, counter cleared to 0.
  - Otherwise counter increments. When the counter reaches IDLE_CYCLES-1 with busy low, go to GATED. The net effect is exactly IDLE_CYCLES consecutive idle cycles inside DRAIN.
- GATED:
  - Outputs: en_o=0, gated_o=1, ready_o=0.
  - Go to WAKE when gate_req_i=0, start_pending_i=1 or test_en_i=1; counter cleared.
  - cgra_busy_i is ignored; it is a don't-care while gated.
- WAKE:
  - Outputs: en_o=1, gated_o=0, ready_o=0.
  - Counter increments each cycle. After max(WAKE_CYCLES,1) cycles in WAKE, go to RUN.
  - gate_req_i is ignored during WAKE, so no re-gate before RUN. Minimum RUN dwell is 1 cycle.
- Latency:
  - Gate request to en_o=0: 1 + IDLE_CYCLES cycles, if idle throughout.
  - Wake cause to en_o=1: 1 cycle.
  - Wake cause to ready_o=1: 1 + max(WAKE_CYCLES,1) cycles.
- Simultaneous events:
  - start_pending_i=1 with gate_req_i=1 in RUN: stay in RUN.
  - Busy and abort in the same DRAIN cycle: abort wins.
- Counter:
  - Saturates at its terminal value and never wraps.
  - Cleared on every state entry.
- No combinational path from any input to any output.

Optional Feature:
- Macro: CGRA_CLK_GATE_STATS_EN.
- When defined, add:
  - Output gated_cycles_o, 32 bits: counts cycles with state=GATED and wraps at 2^32. Reset to 0.
  - Output gate_events_o, 16 bits: increments on each DRAIN→GATED transition and saturates at 0xFFFF. Reset to 0.
  - Input stats_clr_i, 1 bit: synchronous clear of both counters. Clear takes priority over a same-cycle increment.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-GATED, then deassert → next cycle en_o=1, ready_o=1, state_o=0; stats counters = 0 (with CGRA_CLK_GATE_STATS_EN).
- IDLE_CYCLES=4, busy=0, pulse gate_req_i high and hold → en_o falls exactly 5 cycles after the request edge; gated_o=1.
- cgra_busy_i=1 for 1 cycle in the 3rd DRAIN cycle → idle count restarts; en_o falls 4 cycles after busy deasserts; gate_events_o increments by exactly 1.
- In GATED, assert start_pending_i with gate_req_i still 1 and WAKE_CYCLES=2:
  - en_o=1 after 1 cycle; ready_o=1 after 3 cycles.
  - The FSM must not re-enter DRAIN until start_pending_i=0.
- test_en_i=1 while gate_req_i=1 → FSM never leaves RUN, en_o stays 1; asserting test_en_i in GATED → WAKE then RUN.
- WAKE_CYCLES=0: wake causes exactly 1 WAKE cycle. gated_cycles_o equals the number of GATED cycles. stats_clr_i asserted in the same cycle as an increment → counter reads 0.
